pv_override_reg: RTL and testbench

//  Register of WIDTH bits with NCH part-select override channels (synthesisable procedural assign/deassign).

---
 rtl/pv_override_reg_if.sv | 49 ++++
 rtl/pv_override_reg.sv | 152 +++++++++++++++
 tb/tb_pv_override_reg.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pv_override_reg_if.sv
// Bus bundle for pv_override_reg: normal write port, override channel
// requests and register/status outputs.
// Optional feature macro: PV_TIMED_EN adds asg_dur and tmo.
interface pv_override_reg_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned IDXW = $clog2(WIDTH);

  logic                  wr_en;
  logic [WIDTH-1:0]      wr_data;
  logic [WIDTH-1:0]      wr_mask;
  logic [NCH-1:0]        asg_en;
  logic [NCH-1:0]        deasg_en;
  logic [NCH*IDXW-1:0]   asg_lsb;
  logic [NCH*IDXW-1:0]   asg_msb;
  logic [NCH*WIDTH-1:0]  asg_val;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      ovr_mask;
  logic                  err;
`ifdef PV_TIMED_EN
  logic [NCH*CNT_W-1:0]  asg_dur;
  logic [NCH-1:0]        tmo;
`endif

  // Reject meaningless configurations at elaboration
  if (WIDTH < 2 || NCH < 1 || CNT_W < 1) begin : g_param_chk
    $error("pv_override_reg_if: illegal parameter set");
  end

  modport master (
    output wr_en, wr_data, wr_mask, asg_en, deasg_en, asg_lsb, asg_msb, asg_val,
`ifdef PV_TIMED_EN
    output asg_dur,
    input  tmo,
`endif
    input  q, ovr_mask, err
  );

  modport slave (
    input  wr_en, wr_data, wr_mask, asg_en, deasg_en, asg_lsb, asg_msb, asg_val,
`ifdef PV_TIMED_EN
    input  asg_dur,
    output tmo,
`endif
    output q, ovr_mask, err
  );
endinterface

// File: rtl/pv_override_reg.sv
// Register with NCH part-select override channels (synthesisable
// assign/deassign). Assigned bit ranges track a live source; released
// bits hold until the next normal write. Lower channel index wins.
// Optional feature macro: PV_TIMED_EN adds per-channel auto-release counters.
module pv_override_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  pv_override_reg_if.slave bus
);
  localparam int unsigned IDXW = $clog2(WIDTH);

  // Reject meaningless configurations at elaboration
  if (WIDTH < 2 || NCH < 1 || CNT_W < 1) begin : g_param_chk
    $error("pv_override_reg: illegal parameter set");
  end

  logic [NCH-1:0]   act_q, act_d;
  logic [IDXW-1:0]  lsb_q [NCH];
  logic [IDXW-1:0]  msb_q [NCH];
  logic [IDXW-1:0]  lsb_d [NCH];
  logic [IDXW-1:0]  msb_d [NCH];
  logic [NCH-1:0]   ill;
  logic [NCH-1:0]   oor;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] cov_q, cov_d;
  logic             err_q;
`ifdef PV_TIMED_EN
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   tmo_q, tmo_d;
`endif

  // msb beyond the register is only encodable when WIDTH is not a power of two
  for (genvar c = 0; c < NCH; c++) begin : g_oor
    if ((1 << IDXW) > WIDTH) begin : g_chk
      assign oor[c] = 32'(bus.asg_msb[c*IDXW +: IDXW]) >= WIDTH;
    end else begin : g_none
      assign oor[c] = 1'b0;
    end
  end

  // Channel state: timeout, then deassign, then assign (assign wins)
  always_comb begin
    logic [IDXW-1:0] a_lsb;
    logic [IDXW-1:0] a_msb;
    act_d = act_q;
    lsb_d = lsb_q;
    msb_d = msb_q;
    ill   = '0;
    a_lsb = '0;
    a_msb = '0;
`ifdef PV_TIMED_EN
    cnt_d = cnt_q;
    tmo_d = '0;
`endif
    for (int c = 0; c < int'(NCH); c++) begin
      a_lsb = bus.asg_lsb[c*IDXW +: IDXW];
      a_msb = bus.asg_msb[c*IDXW +: IDXW];
`ifdef PV_TIMED_EN
      if (act_q[c] && cnt_q[c] != '0) begin
        if (cnt_q[c] == CNT_W'(1)) begin
          act_d[c] = 1'b0;
          cnt_d[c] = '0;
          tmo_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
        end
      end
`endif
      if (bus.deasg_en[c]) begin
        act_d[c] = 1'b0;
`ifdef PV_TIMED_EN
        cnt_d[c] = '0;
        tmo_d[c] = 1'b0;
`endif
      end
      if (bus.asg_en[c]) begin
        if (a_msb < a_lsb || oor[c]) begin
          ill[c] = 1'b1;
        end else begin
          act_d[c] = 1'b1;
          lsb_d[c] = a_lsb;
          msb_d[c] = a_msb;
`ifdef PV_TIMED_EN
          cnt_d[c] = bus.asg_dur[c*CNT_W +: CNT_W];
          tmo_d[c] = 1'b0;
`endif
        end
      end
    end
  end

  // Bit update: override from lowest covering channel, else masked write, else hold
  always_comb begin
    logic [WIDTH-1:0] sh;
    sh    = '0;
    cov_d = '0;
    q_d   = q_q;
    if (bus.wr_en) q_d = (q_q & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
    for (int c = int'(NCH) - 1; c >= 0; c--) begin
      sh = bus.asg_val[c*WIDTH +: WIDTH] << lsb_d[c];
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (act_d[c] && i >= int'(lsb_d[c]) && i <= int'(msb_d[c])) begin
          cov_d[i] = 1'b1;
          q_d[i]   = sh[i];
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= '0;
      q_q   <= '0;
      cov_q <= '0;
      err_q <= 1'b0;
      for (int c = 0; c < int'(NCH); c++) begin
        lsb_q[c] <= '0;
        msb_q[c] <= '0;
`ifdef PV_TIMED_EN
        cnt_q[c] <= '0;
`endif
      end
`ifdef PV_TIMED_EN
      tmo_q <= '0;
`endif
    end else begin
      act_q <= act_d;
      lsb_q <= lsb_d;
      msb_q <= msb_d;
      q_q   <= q_d;
      cov_q <= cov_d;
      err_q <= |ill;
`ifdef PV_TIMED_EN
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
`endif
    end
  end

  assign bus.q        = q_q;
  assign bus.ovr_mask = cov_q;
  assign bus.err      = err_q;
`ifdef PV_TIMED_EN
  assign bus.tmo      = tmo_q;
`endif
endmodule

// File: tb/tb_pv_override_reg.sv
// Directed self-checking bench for pv_override_reg (WIDTH=4, NCH=2).
module tb_pv_override_reg;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned NCH   = 2;
  localparam int unsigned CNT_W = 8;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  pv_override_reg_if #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) bus ();

  pv_override_reg #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clr_req();
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.wr_mask  = '0;
    bus.asg_en   = '0;
    bus.deasg_en = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr_req();
  endtask

  task automatic set_ch(input int c, input int lsb, input int msb, input logic [3:0] val);
    bus.asg_lsb[c*2 +: 2] = 2'(lsb);
    bus.asg_msb[c*2 +: 2] = 2'(msb);
    bus.asg_val[c*4 +: 4] = val;
    bus.asg_en[c]         = 1'b1;
  endtask

  task automatic set_val(input int c, input logic [3:0] val);
    bus.asg_val[c*4 +: 4] = val;
  endtask

  task automatic wr(input logic [3:0] data, input logic [3:0] mask);
    bus.wr_en   = 1'b1;
    bus.wr_data = data;
    bus.wr_mask = mask;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] eq, input logic [3:0] eovr,
                           input logic eerr);
    chk({tag, ".q"},   8'(bus.q),        8'(eq));
    chk({tag, ".ovr"}, 8'(bus.ovr_mask), 8'(eovr));
    chk({tag, ".err"}, 8'(bus.err),      8'(eerr));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clr_req();
    bus.asg_lsb = '0;
    bus.asg_msb = '0;
    bus.asg_val = '0;
`ifdef PV_TIMED_EN
    bus.asg_dur = '0;
`endif
    #12;
    chk_state("reset", 4'b0000, 4'b0000, 1'b0);
`ifdef PV_TIMED_EN
    chk("reset.tmo", 8'(bus.tmo), 8'h00);
`endif
    rst_n = 1'b1;

    // 1: reset while ch0 is overriding
    set_ch(0, 0, 1, 4'b0011);
    step();
    chk_state("t1.ovr_on", 4'b0011, 4'b0011, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk_state("t1.async_rst", 4'b0000, 4'b0000, 1'b0);
    #1 rst_n = 1'b1;
    set_val(0, 4'b1111);
    step();
    chk_state("t1.idle_after", 4'b0000, 4'b0000, 1'b0);

    // 2: assign discards same-cycle write; second channel; write to free bit
    set_ch(0, 0, 0, 4'b0001);
    wr(4'b0000, 4'b0001);
    step();
    chk_state("t2.asg0", 4'b0001, 4'b0001, 1'b0);
    set_ch(1, 2, 3, 4'b0011);
    step();
    chk_state("t2.asg1", 4'b1101, 4'b1101, 1'b0);
    wr(4'b0010, 4'b0010);
    step();
    chk_state("t2.wr_bit1", 4'b1111, 4'b1101, 1'b0);

    // 3: write lands with deassign; released bit holds
    bus.deasg_en[0] = 1'b1;
    wr(4'b0000, 4'b1111);
    step();
    chk_state("t3.deasg0_wr", 4'b1100, 4'b1100, 1'b0);
    bus.deasg_en[1] = 1'b1;
    wr(4'b0000, 4'b1000);
    step();
    chk_state("t3.deasg1_wr", 4'b0100, 4'b0000, 1'b0);
    step();
    chk_state("t3.hold", 4'b0100, 4'b0000, 1'b0);

    // 4: overlapping channels, lower index wins, handoff on deassign
    set_ch(0, 1, 2, 4'b0001);
    set_ch(1, 1, 3, 4'b0111);
    step();
    chk_state("t4.overlap", 4'b1010, 4'b1110, 1'b0);
    bus.deasg_en[0] = 1'b1;
    step();
    chk_state("t4.handoff", 4'b1110, 4'b1110, 1'b0);
    set_val(1, 4'b0010);
    step();
    chk_state("t4.src_track", 4'b0100, 4'b1110, 1'b0);

    // 5: illegal requests leave state untouched
    set_ch(1, 2, 1, 4'b0010);
    step();
    chk_state("t5.ill_a", 4'b0100, 4'b1110, 1'b1);
    step();
    chk_state("t5.err_clr", 4'b0100, 4'b1110, 1'b0);
    set_ch(1, 3, 0, 4'b0010);
    step();
    chk_state("t5.ill_b", 4'b0100, 4'b1110, 1'b1);
    set_ch(1, 2, 1, 4'b0010);
    bus.deasg_en[1] = 1'b1;
    step();
    chk_state("t5.ill_deasg", 4'b0100, 4'b0000, 1'b1);
    step();
    chk_state("t5.err_clr2", 4'b0100, 4'b0000, 1'b0);

    // Single-bit assign, then re-assign replaces range
    set_ch(0, 3, 3, 4'b0001);
    step();
    chk_state("t5.single_bit", 4'b1100, 4'b1000, 1'b0);
    set_ch(0, 0, 0, 4'b0001);
    step();
    chk_state("t5.reassign", 4'b1101, 4'b0001, 1'b0);
    bus.deasg_en[0] = 1'b1;
    step();
    chk_state("t5.release", 4'b1101, 4'b0000, 1'b0);

`ifdef PV_TIMED_EN
    // 6: timed auto-release after 3 edges
    set_ch(0, 0, 1, 4'b0010);
    bus.asg_dur[0 +: 8] = 8'd3;
    step();
    chk_state("t6.e0", 4'b1110, 4'b0011, 1'b0);
    chk("t6.e0.tmo", 8'(bus.tmo), 8'h00);
    wr(4'b0001, 4'b0001);
    step();
    chk_state("t6.e1", 4'b1110, 4'b0011, 1'b0);
    chk("t6.e1.tmo", 8'(bus.tmo), 8'h00);
    step();
    chk_state("t6.e2", 4'b1110, 4'b0011, 1'b0);
    chk("t6.e2.tmo", 8'(bus.tmo), 8'h00);
    step();
    chk_state("t6.e3", 4'b1110, 4'b0000, 1'b0);
    chk("t6.e3.tmo", 8'(bus.tmo), 8'h01);
    wr(4'b0001, 4'b0001);
    step();
    chk_state("t6.wr_after", 4'b1111, 4'b0000, 1'b0);
    chk("t6.tmo_clr", 8'(bus.tmo), 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
